// File: rtl/hfsdr_stream_pkg.sv
// Shared types and helpers for the ADC stream packer: header magic, framer states,
// sample sign extension and per-strobe word count.
package hfsdr_stream_pkg;

    localparam logic [15:0] HDR_MAGIC = 16'hA5C3;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PAYLOAD,
        PAD
    } state_t;

    // Sign-extend the low w bits of raw to a full 16-bit sample.
    function automatic logic [15:0] sign_extend(input logic [15:0] raw, input int unsigned w);
        logic signed [15:0] shifted;
        shifted = $signed(raw << (16 - w));
        return 16'(shifted >>> (16 - w));
    endfunction

    // Most words a single strobe can produce.
    function automatic int unsigned words_per_strobe(input int unsigned ch_n);
        return (ch_n == 4) ? 2 : 1;
    endfunction

endpackage

// File: rtl/stream_word_fifo.sv
// Single-clock 32-bit word FIFO; accepts up to two words per cycle, pops one.
module stream_word_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             wr_cnt,
    input  logic [63:0]            wr_data,
    input  logic                   rd_en,
    output logic [31:0]            rd_data_c,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign rd_data_c = mem[rd_ptr];

    // Low word of wr_data is always written first.
    always_ff @(posedge clk) begin
        if (wr_cnt != 2'd0) mem[wr_ptr] <= wr_data[31:0];
        if (wr_cnt == 2'd2) mem[wr_ptr + AW'(1)] <= wr_data[63:32];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(wr_cnt);
            rd_ptr <= rd_ptr + AW'(rd_en);
            count  <= count + CW'(wr_cnt) - CW'(rd_en);
        end
    end

endmodule

// File: rtl/adc_stream_packer.sv
// Packs CH_N-channel ADC sample sets into framed 32-bit words for the txfifo.
// Optional ADC_TESTPAT_EN adds test_mode, replacing adc_data with a per-channel ramp.
module adc_stream_packer
    import hfsdr_stream_pkg::*;
#(
    parameter int unsigned ADC_W       = 14,
    parameter int unsigned CH_N        = 2,
    parameter int unsigned FRAME_WORDS = 256,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic                   adc_clk,
    input  logic                   RESET_N,
    input  logic                   enable,
    input  logic                   adc_valid,
    input  logic [CH_N*ADC_W-1:0]  adc_data,
    output logic [31:0]            out_data,
    output logic                   out_wr,
    input  logic                   out_full,
    output logic [15:0]            drop_cnt,
    output logic                   overflow,
`ifdef ADC_TESTPAT_EN
    input  logic                   test_mode,
`endif
    output logic [15:0]            frame_seq
);

    localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned WPS = words_per_strobe(CH_N);

    state_t                state;
    logic [CH_N*ADC_W-1:0] raw_c;
    logic [15:0]           samp [CH_N];
    logic [63:0]           set_words_c;
    logic [1:0]            need_c;
    logic [CW-1:0]         fifo_count;
    logic [CW-1:0]         space_c;
    logic [31:0]           fifo_rd_c;
    logic                  cap_c, accept_c, drop_c, pop_c;
    logic                  word_pending, hdr_loaded;
    logic                  xfer_c, load_ok_c, last_c;
    logic [15:0]           pay_cnt;

    assign cap_c = enable && adc_valid;

`ifdef ADC_TESTPAT_EN
    logic [ADC_W-1:0] ramp;

    always_ff @(posedge adc_clk or negedge RESET_N) begin
        if (!RESET_N)   ramp <= '0;
        else if (cap_c) ramp <= ramp + ADC_W'(1);
    end
`endif

    for (genvar c = 0; c < CH_N; c++) begin : g_samp
`ifdef ADC_TESTPAT_EN
        assign raw_c[c*ADC_W +: ADC_W] = test_mode ? ramp + ADC_W'(c) : adc_data[c*ADC_W +: ADC_W];
`else
        assign raw_c[c*ADC_W +: ADC_W] = adc_data[c*ADC_W +: ADC_W];
`endif
        assign samp[c] = sign_extend(16'(raw_c[c*ADC_W +: ADC_W]), ADC_W);
    end

    // Word assembly per channel count; single-channel mode pairs strobes via a half-word holder.
    if (CH_N == 1) begin : g_ch1
        logic [15:0] half_word;
        logic        half_valid;

        assign set_words_c = {32'h0, samp[0], half_word};
        assign need_c      = half_valid ? 2'd1 : 2'd0;

        always_ff @(posedge adc_clk or negedge RESET_N) begin
            if (!RESET_N) begin
                half_word  <= '0;
                half_valid <= 1'b0;
            end else if (!enable) begin
                half_valid <= 1'b0;
            end else if (cap_c && !half_valid) begin
                half_word  <= samp[0];
                half_valid <= 1'b1;
            end else if (accept_c) begin
                half_valid <= 1'b0;
            end
        end
    end else if (WPS == 2) begin : g_ch4
        assign set_words_c = {samp[3], samp[2], samp[1], samp[0]};
        assign need_c      = 2'd2;
    end else begin : g_ch2
        assign set_words_c = {32'h0, samp[1], samp[0]};
        assign need_c      = 2'd1;
    end

    // Space is judged after this cycle's pop, so a full FIFO that pops still takes one word.
    assign space_c  = CW'(FIFO_DEPTH) - fifo_count + CW'(pop_c);
    assign accept_c = cap_c && (space_c >= CW'(need_c));
    assign drop_c   = cap_c && !accept_c;

    stream_word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (adc_clk),
        .rst_n     (RESET_N),
        .wr_cnt    (accept_c ? need_c : 2'd0),
        .wr_data   (set_words_c),
        .rd_en     (pop_c),
        .rd_data_c (fifo_rd_c),
        .count     (fifo_count)
    );

    assign xfer_c    = word_pending && !out_full;
    assign out_wr    = xfer_c;
    assign load_ok_c = !word_pending || xfer_c;
    assign pop_c     = (state == PAYLOAD) && load_ok_c && (fifo_count != '0);
    assign last_c    = (pay_cnt == 16'(FRAME_WORDS - 1));

    always_ff @(posedge adc_clk or negedge RESET_N) begin
        if (!RESET_N) begin
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else if (drop_c) begin
            overflow <= 1'b1;
            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end

    // Framer and output register; pay_cnt counts payload/pad words loaded this frame.
    always_ff @(posedge adc_clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= IDLE;
            out_data     <= '0;
            word_pending <= 1'b0;
            hdr_loaded   <= 1'b0;
            pay_cnt      <= '0;
            frame_seq    <= '0;
        end else begin
            if (xfer_c) word_pending <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) state <= HDR;
                end
                HDR: begin
                    if (!hdr_loaded && load_ok_c) begin
                        out_data     <= {HDR_MAGIC, frame_seq};
                        word_pending <= 1'b1;
                        hdr_loaded   <= 1'b1;
                    end else if (hdr_loaded && xfer_c) begin
                        hdr_loaded <= 1'b0;
                        frame_seq  <= frame_seq + 16'd1;
                        pay_cnt    <= '0;
                        state      <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (pop_c) begin
                        out_data     <= fifo_rd_c;
                        word_pending <= 1'b1;
                        pay_cnt      <= pay_cnt + 16'd1;
                        if (last_c) state <= enable ? HDR : IDLE;
                    end else if (!enable && fifo_count == '0) begin
                        state <= PAD;
                    end
                end
                PAD: begin
                    if (load_ok_c) begin
                        out_data     <= '0;
                        word_pending <= 1'b1;
                        pay_cnt      <= pay_cnt + 16'd1;
                        if (last_c) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
